gc_loader_fsm: RTL

Configuration loader for the global controller. It answers the controller FSM's `conf_en` request by pulling a packed configuration word stream from the host/config memory. It distributes the payload words as register writes to the controller's sub-blocks: initializer, re-initializer, iteration-vector generator and control-signal generator. It then raises `config_done`, which lets the controller FSM leave its configure state and start counting iteration intervals.

---
 rtl/gc_loader_fsm_pkg.sv | 22 ++
 rtl/gc_loader_fsm.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/gc_loader_fsm_pkg.sv
// rtl/gc_loader_fsm_pkg.sv - shared stream opcodes, header field positions and loader state encoding
package gc_loader_fsm_pkg;

    localparam logic [3:0] OP_SECTION = 4'h1;
    localparam logic [3:0] OP_END     = 4'hF;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int BLK_MSB = 27;
    localparam int BLK_LSB = 24;
    localparam int CNT_MSB = 15;
    localparam int CNT_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/gc_loader_fsm.sv
// rtl/gc_loader_fsm.sv - parses the packed config stream into per-block register writes
// Sections of N words go to addresses 0..N-1 of one block; END raises config_done.
module gc_loader_fsm #(
    parameter int NUM_BLOCKS = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  gc_clk,
    input  logic                  reset,
    input  logic                  conf_en,
    input  logic                  cfg_valid,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  cfg_ready,
    output logic [NUM_BLOCKS-1:0] wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  config_done,
    output logic                  cfg_error
);
    import gc_loader_fsm_pkg::*;

    localparam int BLK_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int CNT_W     = ADDR_WIDTH + 1;
    localparam int MAX_WORDS = 1 << ADDR_WIDTH;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [BLK_W-1:0]        r_blk;
    logic [CNT_W-1:0]        r_remaining;
    logic [ADDR_WIDTH-1:0]   r_addr_cnt;
    logic [NUM_BLOCKS-1:0]   r_wr_en;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic                    r_config_done;
    logic                    r_cfg_error;

    logic [3:0]              w_op;
    logic [3:0]              w_blk;
    logic [15:0]             w_count;
    logic                    w_hdr_err;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_write;
    logic [NUM_BLOCKS-1:0]   w_onehot;

    assign w_op     = cfg_data[OP_MSB:OP_LSB];
    assign w_blk    = cfg_data[BLK_MSB:BLK_LSB];
    assign w_count  = cfg_data[CNT_MSB:CNT_LSB];
    assign w_ready  = (r_state == ST_HEADER) || (r_state == ST_DATA);
    assign w_accept = w_ready && cfg_valid;
    assign w_onehot = {{(NUM_BLOCKS-1){1'b0}}, 1'b1} << r_blk;

    // END ignores its block/count fields, so range checks apply to SECTION only
    always_comb begin
        w_hdr_err = 1'b0;
        if (w_op == OP_SECTION) begin
            w_hdr_err = (int'(w_blk) >= NUM_BLOCKS) || (int'(w_count) > MAX_WORDS);
        end else if (w_op != OP_END) begin
            w_hdr_err = 1'b1;
        end
    end

    always_ff @(posedge gc_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (conf_en) begin
                    w_state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (w_accept) begin
                    if (w_hdr_err) begin
                        w_state_next = ST_ERROR;
                    end else if (w_op == OP_END) begin
                        w_state_next = ST_DONE;
                    end else if (w_count != 16'd0) begin
                        w_state_next = ST_DATA;
                        w_load       = 1'b1;
                    end
                end
                if (!conf_en) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_next = ST_HEADER;
                    end
                end
                // an abort still lets the word accepted this cycle be written
                if (!conf_en) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DONE, ST_ERROR: begin
                w_state_next = r_state;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge gc_clk) begin
        if (reset) begin
            r_blk         <= '0;
            r_remaining   <= '0;
            r_addr_cnt    <= '0;
            r_wr_en       <= '0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_config_done <= 1'b0;
            r_cfg_error   <= 1'b0;
        end else begin
            r_wr_en <= w_write ? w_onehot : '0;
            if (w_write) begin
                r_wr_addr   <= r_addr_cnt;
                r_wr_data   <= cfg_data;
                r_addr_cnt  <= r_addr_cnt + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - CNT_W'(1);
            end
            if (w_load) begin
                r_blk       <= w_blk[BLK_W-1:0];
                r_remaining <= w_count[CNT_W-1:0];
                r_addr_cnt  <= '0;
            end
            r_config_done <= (w_state_next == ST_DONE);
            r_cfg_error   <= (w_state_next == ST_ERROR);
        end
    end

    assign cfg_ready   = w_ready;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign config_done = r_config_done;
    assign cfg_error   = r_cfg_error;

endmodule
